fetch_unit: RTL and testbench

Instruction fetch front end. It is the reader side of the instruction memory port: it drives a 12-bit word address and consumes the 19-bit instruction, which the memory returns registered one clock later. It tracks the in-flight request and buffers returned words in a 2-entry skid buffer. It presents {pc, instruction} to decode with a valid/ready handshake, and supports branch redirect, fetch enable and pc wrap-around.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/fetch_skid_buffer.sv | 59 +++++
 rtl/fetch_unit.sv | 88 ++++++++
 tb/tb_fetch_unit.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: address/instruction widths, reset vector
// and the {pc, instruction} packet handed from fetch to decode.
package cpu_pkg;

  localparam int ADDR_W  = 12;
  localparam int INSTR_W = 19;
  localparam int PKT_W   = ADDR_W + INSTR_W;

  localparam logic [ADDR_W-1:0] RESET_PC = '0;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instruction;
  } fetch_packet_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// Two-entry FIFO between the instruction memory return path and decode.
// The head lives in its own register so decode sees it without a mux.
module fetch_skid_buffer #(
  parameter int DATA_W = 31,
  parameter int DEPTH  = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [CNT_W-1:0]  count,
  output logic              head_valid,
  output logic [DATA_W-1:0] head_data
);

  logic [DATA_W-1:0] head_q;
  logic [DATA_W-1:0] tail_q;
  logic [CNT_W-1:0]  count_q;

  // Flush only clears occupancy; head data is left stale on purpose.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      count_q <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == '0) head_q <= push_data;
          else               tail_q <= push_data;
          count_q <= count_q + CNT_W'(1);
        end
        2'b01: begin
          if (count_q == CNT_W'(2)) head_q <= tail_q;
          count_q <= count_q - CNT_W'(1);
        end
        2'b11: begin
          if (count_q == CNT_W'(1)) begin
            head_q <= push_data;
          end else begin
            head_q <= tail_q;
            tail_q <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign count      = count_q;
  assign head_valid = (count_q != '0);
  assign head_data  = head_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues word addresses to a registered memory,
// tracks the one in-flight request and queues returned words for decode.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W    = cpu_pkg::ADDR_W,
  parameter int                INSTR_W   = cpu_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC  = cpu_pkg::RESET_PC,
  parameter int                BUF_DEPTH = 2
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               fetch_enable,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [ADDR_W-1:0]  imem_address,
  input  logic [INSTR_W-1:0] imem_instruction,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instruction,
  output logic [ADDR_W-1:0]  out_pc
);

  localparam int DATA_W = ADDR_W + INSTR_W;
  localparam int CNT_W  = $clog2(BUF_DEPTH + 1);

  // Handshake: a word moves to decode on an edge where out_valid and
  // out_ready are both high and no redirect is present; a redirect kills
  // the head, so decode must ignore it in that cycle.

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] req_pc_q;
  logic              req_valid_q;

  logic              pop;
  logic              push;
  logic              issue;
  logic [CNT_W-1:0]  count;
  logic [CNT_W:0]    occupancy;
  logic [DATA_W-1:0] head_data;

  assign imem_address = redirect_valid ? redirect_pc : pc_q;

  assign pop  = out_valid & out_ready & ~redirect_valid;
  assign push = req_valid_q & ~redirect_valid;

  // Slots that will be taken after this edge if nothing new is issued;
  // issuing is only allowed when the returning word is sure to fit.
  always_comb begin
    occupancy = {1'b0, count} + {{CNT_W{1'b0}}, req_valid_q}
              - {{CNT_W{1'b0}}, pop};
    issue     = redirect_valid
              | (fetch_enable & (occupancy < (CNT_W+1)'(BUF_DEPTH)));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q        <= RESET_PC;
      req_pc_q    <= '0;
      req_valid_q <= 1'b0;
    end else begin
      req_valid_q <= issue;
      if (issue) begin
        req_pc_q <= imem_address;
        pc_q     <= imem_address + ADDR_W'(1);
      end
    end
  end

  fetch_skid_buffer #(
    .DATA_W (DATA_W),
    .DEPTH  (BUF_DEPTH)
  ) u_skid (
    .clock      (clock),
    .reset_n    (reset_n),
    .flush      (redirect_valid),
    .push       (push),
    .push_data  ({req_pc_q, imem_instruction}),
    .pop        (pop),
    .count      (count),
    .head_valid (out_valid),
    .head_data  (head_data)
  );

  assign out_pc          = head_data[DATA_W-1:INSTR_W];
  assign out_instruction = head_data[INSTR_W-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a registered memory model, an expected
// packet queue fed by the stimulus and a monitor that checks every handshake.
module tb_fetch_unit;
  import cpu_pkg::*;

  logic               clock = 1'b0;
  logic               reset_n = 1'b0;
  logic               fetch_enable = 1'b0;
  logic               redirect_valid = 1'b0;
  logic [ADDR_W-1:0]  redirect_pc = '0;
  logic [ADDR_W-1:0]  imem_address;
  logic [INSTR_W-1:0] imem_instruction = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [INSTR_W-1:0] out_instruction;
  logic [ADDR_W-1:0]  out_pc;

  logic [PKT_W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  fetch_unit dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .fetch_enable     (fetch_enable),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .imem_address     (imem_address),
    .imem_instruction (imem_instruction),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_instruction  (out_instruction),
    .out_pc           (out_pc)
  );

  // ---------------- clock / memory model ----------------
  always #5 clock = ~clock;

  function automatic logic [INSTR_W-1:0] mem_f(input logic [ADDR_W-1:0] a);
    case (a)
      12'd0:   mem_f = 19'd25;
      12'd1:   mem_f = 19'd23;
      12'd2:   mem_f = 19'd20;
      12'd3:   mem_f = 19'd12;
      12'd100: mem_f = 19'd30;
      default: mem_f = INSTR_W'(a) * 19'd3 + 19'd7;
    endcase
  endfunction

  always @(posedge clock) imem_instruction <= mem_f(imem_address);

  function automatic logic [PKT_W-1:0] pkt(input int pc);
    fetch_packet_t p;
    p.pc          = ADDR_W'(pc);
    p.instruction = mem_f(ADDR_W'(pc));
    return p;
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clock) begin
    if (reset_n && out_valid && out_ready && !redirect_valid) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_output: got pc=%0d instr=%0d, required none",
                 out_pc, out_instruction);
      end else begin
        logic [PKT_W-1:0] e;
        e = exp_q.pop_front();
        if ({out_pc, out_instruction} !== e) begin
          n_err++;
          $display("FAIL output_pkt: got pc=%0d instr=%0d, required pc=%0d instr=%0d",
                   out_pc, out_instruction, e[PKT_W-1:INSTR_W], e[INSTR_W-1:0]);
        end
      end
    end
  end

  // ---------------- driver / check tasks ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input logic fe, input logic rdy);
    reset_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    fetch_enable = fe;
    out_ready = rdy;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  // Called just after an edge: keeps out_ready high until every expected
  // packet has been accepted, then stalls decode.
  task automatic drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: got %0d pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
    out_ready = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    // reset state and first-fetch latency, free-run
    reset_n = 1'b0;
    #12;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_pc", 32'(out_pc), 0);
    check("rst_out_instr", 32'(out_instruction), 0);
    check("rst_imem_addr", 32'(imem_address), 32'(RESET_PC));
    do_reset(1'b1, 1'b1);
    exp_q.push_back(pkt(0));
    exp_q.push_back(pkt(1));
    exp_q.push_back(pkt(2));
    @(negedge clock);
    check("edge1_out_valid", 32'(out_valid), 0);
    check("edge1_imem_addr", 32'(imem_address), 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("freerun_no_gap", 32'(out_valid), 1);
    end
    step();
    drain("freerun", 10);

    // decode stall with two words buffered, then back-to-back resume
    do_reset(1'b1, 1'b0);
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("stall_imem_addr", 32'(imem_address), 2);
      check("stall_head_pc", 32'(out_pc), 0);
    end
    step();
    for (int i = 0; i < 4; i++) exp_q.push_back(pkt(i));
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("resume_no_gap", 32'(out_valid), 1);
    end
    step();
    drain("resume", 10);

    // redirect while the buffer is full
    do_reset(1'b1, 1'b0);
    repeat (4) step();
    redirect_valid = 1'b1;
    redirect_pc = 12'd100;
    out_ready = 1'b1;
    exp_q.push_back(pkt(100));
    exp_q.push_back(pkt(101));
    exp_q.push_back(pkt(102));
    @(negedge clock);
    check("redir_imem_addr", 32'(imem_address), 100);
    step();
    redirect_valid = 1'b0;
    @(negedge clock);
    check("redir_flush_valid", 32'(out_valid), 0);
    @(negedge clock);
    check("redir_latency_valid", 32'(out_valid), 1);
    step();
    drain("redir_full", 10);

    // redirect coinciding with out_ready and a landing word
    do_reset(1'b1, 1'b1);
    exp_q.push_back(pkt(0));
    step();
    step();
    step();
    redirect_valid = 1'b1;
    redirect_pc = 12'd200;
    exp_q.push_back(pkt(200));
    exp_q.push_back(pkt(201));
    @(negedge clock);
    check("redir_killed_head_pc", 32'(out_pc), 1);
    step();
    redirect_valid = 1'b0;
    @(negedge clock);
    check("redir_land_dropped", 32'(out_valid), 0);
    @(negedge clock);
    check("redir_target_valid", 32'(out_valid), 1);
    step();
    drain("redir_land", 10);

    // pc wrap-around at the top of the address space
    do_reset(1'b1, 1'b0);
    step();
    redirect_valid = 1'b1;
    redirect_pc = 12'd4095;
    out_ready = 1'b1;
    exp_q.push_back(pkt(4095));
    exp_q.push_back(pkt(0));
    exp_q.push_back(pkt(1));
    @(negedge clock);
    check("wrap_imem_addr", 32'(imem_address), 4095);
    step();
    redirect_valid = 1'b0;
    drain("wrap", 10);

    // fetch_enable low mid-stream, then re-enable
    do_reset(1'b1, 1'b1);
    exp_q.push_back(pkt(0));
    exp_q.push_back(pkt(1));
    step();
    step();
    fetch_enable = 1'b0;
    @(negedge clock);
    @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("fe_low_drained", 32'(out_valid), 0);
      check("fe_low_imem_addr", 32'(imem_address), 2);
    end
    step();
    fetch_enable = 1'b1;
    exp_q.push_back(pkt(2));
    exp_q.push_back(pkt(3));
    drain("fe_resume", 10);

    // asynchronous reset pulse while words are buffered
    @(negedge clock);
    check("pre_pulse_valid", 32'(out_valid), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("pulse_out_valid", 32'(out_valid), 0);
    check("pulse_imem_addr", 32'(imem_address), 32'(RESET_PC));
    out_ready = 1'b1;
    exp_q.push_back(pkt(0));
    exp_q.push_back(pkt(1));
    exp_q.push_back(pkt(2));
    @(negedge clock);
    reset_n = 1'b1;
    step();
    drain("pulse_restart", 12);

    repeat (2) @(negedge clock);
    check("queue_empty", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
